// File: rtl/spi_trigger_master.sv
`default_nettype none
// ============================================================================
// spi_trigger_master : byte-wide SPI master driven by read-to-trigger accesses
// Rev 1.0
// ============================================================================

module spi_trigger_master #(
  parameter int AW        = 12,
  parameter int NUM_CS    = 2,
  parameter int DIV_SLOW  = 30,
  parameter int DIV_FAST  = 1,
  parameter int BURST_LEN = 512
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              BUS_SEL,
  input  logic [AW-1:0]     BUS_ADDR,
  input  logic              BUS_OE_N,
  output logic [15:0]       DATA_OUT,
  output logic              DATA_DRIVE,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NUM_CS-1:0] SPI_CS_N,
  output logic              BUSY,
  output logic              LOCKED
);

  localparam int c_FW      = AW - 8;
  localparam int c_DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int c_DW      = (c_DIV_MAX < 1) ? 1 : $clog2(c_DIV_MAX + 1);

  localparam logic [c_FW-1:0] c_F_SEND   = c_FW'(0);
  localparam logic [c_FW-1:0] c_F_CS     = c_FW'(3);
  localparam logic [c_FW-1:0] c_F_SPEED  = c_FW'(4);
  localparam logic [c_FW-1:0] c_F_LOCK   = c_FW'(5);
  localparam logic [c_FW-1:0] c_F_STATUS = c_FW'(6);
  localparam logic [c_FW-1:0] c_F_BURST  = c_FW'(7);
  localparam logic [c_FW-1:0] c_F_DATA   = c_FW'(8);

  localparam logic [c_DW-1:0] c_DIV_SLOW   = c_DW'(DIV_SLOW);
  localparam logic [c_DW-1:0] c_DIV_FAST   = c_DW'(DIV_FAST);
  localparam logic [9:0]      c_BURST_INIT = 10'(BURST_LEN - 1);
  localparam logic [4:0]      c_STEPS      = 5'd16;

  // OE_N synchroniser; third stage holds the previous synchronised value
  logic oe_s1_q, oe_s2_q, oe_s3_q;

  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [c_DW-1:0]   div_q, div_d;
  logic [4:0]        step_q, step_d;
  logic              high_speed_q, high_speed_d;
  logic              locked_q, locked_d;
  logic              overrun_q, overrun_d;
  logic [9:0]        burst_cnt_q, burst_cnt_d;

  logic [c_FW-1:0]   w_func;
  logic [7:0]        w_pay;
  logic              w_trig;
  logic              w_expire;
  logic              w_done;
  logic              w_free;
  logic [c_DW-1:0]   w_div_reload;
  logic              w_start;
  logic [7:0]        w_start_byte;
  logic [7:0]        w_status_byte;
  logic              w_is_status;
  logic              w_is_data;

  assign w_func       = BUS_ADDR[AW-1:8];
  assign w_pay        = BUS_ADDR[7:0];
  assign w_trig       = oe_s3_q & ~oe_s2_q & BUS_SEL;
  assign w_expire     = (step_q != 5'd0) && (div_q == '0);
  assign w_done       = w_expire && (step_q == 5'd1);
  // The final half-period counts as idle so a trigger can chain the next byte
  assign w_free       = (step_q == 5'd0) || w_done;
  assign w_div_reload = high_speed_q ? c_DIV_FAST : c_DIV_SLOW;

  always_comb begin
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    tx_d         = tx_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    div_d        = div_q;
    step_d       = step_q;
    high_speed_d = high_speed_q;
    locked_d     = locked_q;
    overrun_d    = overrun_q;
    burst_cnt_d  = burst_cnt_q;
    w_start      = 1'b0;
    w_start_byte = 8'hFF;

    if (w_expire) begin
      div_d  = w_div_reload;
      step_d = step_q - 5'd1;
      sclk_d = ~sclk_q;
      if (!sclk_q) begin
        rx_shift_d = {rx_shift_q[6:0], SPI_MISO};
      end else begin
        tx_d = {tx_q[6:0], 1'b1};
      end
      if (w_done) begin
        rx_data_d = rx_shift_q;
      end
    end else if (step_q != 5'd0) begin
      div_d = div_q - c_DW'(1);
    end

    if (w_trig) begin
      case (w_func)
        c_F_SEND: begin
          if (w_free && !locked_q) begin
            w_start      = 1'b1;
            w_start_byte = w_pay;
          end
        end
        c_F_CS: begin
          for (int i = 0; i < NUM_CS; i++) begin
            if (w_pay[6:4] == 3'(i)) begin
              cs_d[i] = w_pay[0];
            end
          end
        end
        c_F_SPEED: begin
          if (w_free) high_speed_d = w_pay[0];
        end
        c_F_LOCK: begin
          if (w_free) locked_d = w_pay[0];
        end
        c_F_STATUS: begin
          overrun_d = 1'b0;
        end
        c_F_BURST: begin
          if (w_free && !locked_q) begin
            w_start     = 1'b1;
            burst_cnt_d = c_BURST_INIT;
          end
        end
        c_F_DATA: begin
          if (!w_free) begin
            overrun_d = 1'b1;
          end else if (burst_cnt_q != 10'd0) begin
            w_start     = 1'b1;
            burst_cnt_d = burst_cnt_q - 10'd1;
          end
        end
        default: ;
      endcase
    end

    // A start overrides the engine's closing step of the previous byte
    if (w_start) begin
      tx_d   = w_start_byte;
      step_d = c_STEPS;
      div_d  = w_div_reload;
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      oe_s1_q      <= 1'b1;
      oe_s2_q      <= 1'b1;
      oe_s3_q      <= 1'b1;
      cs_q         <= '1;
      sclk_q       <= 1'b0;
      tx_q         <= 8'hFF;
      rx_shift_q   <= 8'hFF;
      rx_data_q    <= 8'hFF;
      div_q        <= '0;
      step_q       <= 5'd0;
      high_speed_q <= 1'b0;
      locked_q     <= 1'b1;
      overrun_q    <= 1'b0;
      burst_cnt_q  <= 10'd0;
    end else begin
      oe_s1_q      <= BUS_OE_N;
      oe_s2_q      <= oe_s1_q;
      oe_s3_q      <= oe_s2_q;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      tx_q         <= tx_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      div_q        <= div_d;
      step_q       <= step_d;
      high_speed_q <= high_speed_d;
      locked_q     <= locked_d;
      overrun_q    <= overrun_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = tx_q[7];
  assign SPI_CS_N = cs_q;
  assign BUSY     = (step_q != 5'd0);
  assign LOCKED   = locked_q;

  assign w_is_status   = (w_func == c_F_STATUS);
  assign w_is_data     = (w_func == c_F_DATA);
  assign w_status_byte = {4'b0000, overrun_q, (burst_cnt_q != 10'd0), locked_q, BUSY};
  assign DATA_DRIVE    = BUS_SEL & ~BUS_OE_N & (w_is_status | w_is_data);

  always_comb begin
    DATA_OUT = 16'h0000;
    if (DATA_DRIVE) begin
      DATA_OUT = w_is_data ? {rx_data_q, rx_data_q} : {w_status_byte, w_status_byte};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_trigger_master.sv
`default_nettype none
// ============================================================================
// tb_spi_trigger_master : directed bench for spi_trigger_master
// Rev 1.0
// ============================================================================

module tb_spi_trigger_master;

  logic        clk;
  logic        rst;
  logic        bus_sel;
  logic [11:0] bus_addr;
  logic        bus_oe_n;
  logic [15:0] data_out;
  logic        data_drive;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [1:0]  spi_cs_n;
  logic        busy;
  logic        locked;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] rd_data;
  logic        rd_drive;
  logic        loopback;
  logic [7:0]  slave_q;
  logic [7:0]  slave_byte;
  logic        slave_ld;

  int   busy_run   = 0;
  int   last_len   = 0;
  int   sclk_rises = 0;
  logic busy_prev  = 1'b0;
  logic sclk_prev  = 1'b0;

  spi_trigger_master #(
    .AW        (12),
    .NUM_CS    (2),
    .DIV_SLOW  (30),
    .DIV_FAST  (1),
    .BURST_LEN (4)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .BUS_SEL    (bus_sel),
    .BUS_ADDR   (bus_addr),
    .BUS_OE_N   (bus_oe_n),
    .DATA_OUT   (data_out),
    .DATA_DRIVE (data_drive),
    .SPI_CLK    (spi_clk),
    .SPI_MOSI   (spi_mosi),
    .SPI_MISO   (spi_miso),
    .SPI_CS_N   (spi_cs_n),
    .BUSY       (busy),
    .LOCKED     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: presents its MSB before the first rising edge, shifts on falling
  assign spi_miso = loopback ? spi_mosi : slave_q[7];

  always @(negedge spi_clk or posedge slave_ld) begin
    if (slave_ld) slave_q <= slave_byte;
    else          slave_q <= {slave_q[6:0], 1'b1};
  end

  // Byte-length and SPI clock edge monitor, sampling pre-edge values
  always @(posedge clk) begin
    if (busy && !busy_prev)      busy_run = 1;
    else if (busy)               busy_run = busy_run + 1;
    if (!busy && busy_prev)      last_len = busy_run;
    if (spi_clk && !sclk_prev)   sclk_rises = sclk_rises + 1;
    busy_prev = busy;
    sclk_prev = spi_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_access(input logic [3:0] f, input logic [7:0] p);
    bus_addr = {f, p};
    bus_sel  = 1'b1;
    bus_oe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd_data  = data_out;
    rd_drive = data_drive;
    @(negedge clk);
  endtask

  task automatic end_access();
    bus_oe_n = 1'b1;
    bus_sel  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic access(input logic [3:0] f, input logic [7:0] p);
    start_access(f, p);
    end_access();
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic load_slave(input logic [7:0] b);
    slave_byte = b;
    slave_ld   = 1'b1;
    #1;
    slave_ld   = 1'b0;
  endtask

  logic [31:0] obs_sclk;
  logic [7:0]  obs_mosi;
  int          r0;
  int          r1;
  int          t;

  initial begin
    rst        = 1'b1;
    bus_sel    = 1'b0;
    bus_addr   = 12'h000;
    bus_oe_n   = 1'b1;
    loopback   = 1'b1;
    slave_ld   = 1'b0;
    slave_byte = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_cs_n",   {30'd0, spi_cs_n}, 32'h3);
    check("rst_sclk",   {31'd0, spi_clk},  32'h0);
    check("rst_mosi",   {31'd0, spi_mosi}, 32'h1);
    check("rst_busy",   {31'd0, busy},     32'h0);
    check("rst_locked", {31'd0, locked},   32'h1);
    check("rst_drive",  {31'd0, data_drive}, 32'h0);
    check("rst_dout",   {16'd0, data_out}, 32'h0);

    access(4'h6, 8'h00);
    check("status_rst",   {16'd0, rd_data}, 32'h0202);
    check("status_drive", {31'd0, rd_drive}, 32'h1);

    r0 = sclk_rises;
    access(4'h0, 8'h40);
    repeat (4) @(negedge clk);
    check("send_locked_rises", sclk_rises - r0, 32'd0);
    check("send_locked_busy",  {31'd0, busy}, 32'h0);

    access(4'h5, 8'h00);
    check("unlock", {31'd0, locked}, 32'h0);
    access(4'h4, 8'h01);

    // Fast SEND 0xA5, looped back, traced cycle by cycle from the start edge
    start_access(4'h0, 8'hA5);
    obs_sclk = 32'd0;
    obs_mosi = 8'd0;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) begin
        bus_oe_n = 1'b1;
        bus_sel  = 1'b0;
      end
      obs_sclk[k] = spi_clk;
      if (k % 4 == 2) obs_mosi = {obs_mosi[6:0], spi_mosi};
      @(negedge clk);
    end
    check("a5_busy_end", {31'd0, busy},    32'h0);
    check("a5_sclk_end", {31'd0, spi_clk}, 32'h0);
    check("a5_sclk_pattern", obs_sclk, 32'hCCCC_CCCC);
    check("a5_mosi_bits", {24'd0, obs_mosi}, 32'hA5);
    repeat (2) @(negedge clk);
    check("a5_busy_len", last_len, 32'd32);

    access(4'h8, 8'h00);
    check("a5_rx", {16'd0, rd_data}, 32'hA5A5);
    check("data_drive", {31'd0, rd_drive}, 32'h1);

    // Slow mode, with a SPEED change attempted mid-byte
    access(4'h4, 8'h00);
    access(4'h0, 8'hFF);
    access(4'h4, 8'h01);
    wait_idle("slow_idle");
    check("slow_len", last_len, 32'd496);
    access(4'h0, 8'hFF);
    wait_idle("slow2_idle");
    check("speed_ignored_busy", last_len, 32'd496);
    access(4'h4, 8'h01);

    access(4'h3, 8'h00);
    check("cs0_low", {30'd0, spi_cs_n}, 32'h2);
    access(4'h3, 8'h10);
    check("cs1_low", {30'd0, spi_cs_n}, 32'h0);
    access(4'h3, 8'h11);
    check("cs1_high", {30'd0, spi_cs_n}, 32'h2);
    access(4'h3, 8'h70);
    check("cs_idx_oob", {30'd0, spi_cs_n}, 32'h2);

    // Burst of 4 with a slave pattern, plus an overrun read during byte 1
    loopback = 1'b0;
    load_slave(8'h11);
    r0 = sclk_rises;
    access(4'h7, 8'h00);
    access(4'h8, 8'h00);
    wait_idle("burst1_idle");
    access(4'h6, 8'h00);
    check("overrun_set", {16'd0, rd_data}, 32'h0C0C);
    access(4'h6, 8'h00);
    check("overrun_clr", {16'd0, rd_data}, 32'h0404);

    load_slave(8'h22);
    access(4'h8, 8'h00);
    check("burst_rd1", {16'd0, rd_data}, 32'h1111);
    wait_idle("burst2_idle");
    load_slave(8'h33);
    access(4'h8, 8'h00);
    check("burst_rd2", {16'd0, rd_data}, 32'h2222);
    wait_idle("burst3_idle");
    load_slave(8'h44);
    access(4'h8, 8'h00);
    check("burst_rd3", {16'd0, rd_data}, 32'h3333);
    wait_idle("burst4_idle");
    access(4'h6, 8'h00);
    check("burst_inactive", {16'd0, rd_data}, 32'h0000);

    r1 = sclk_rises;
    check("burst_rises", r1 - r0, 32'd32);
    access(4'h8, 8'h00);
    check("burst_rd4", {16'd0, rd_data}, 32'h4444);
    repeat (4) @(negedge clk);
    check("burst_end_busy",  {31'd0, busy}, 32'h0);
    check("burst_end_rises", sclk_rises - r1, 32'd0);

    // Reset while SPI_CLK is high in the middle of a byte
    loopback = 1'b1;
    start_access(4'h0, 8'h3C);
    end_access();
    t = 0;
    while (!spi_clk && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_sclk_high", {31'd0, spi_clk}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", {30'd0, spi_cs_n}, 32'h3);
    check("mid_rst_sclk", {31'd0, spi_clk},  32'h0);
    check("mid_rst_busy", {31'd0, busy},     32'h0);
    check("mid_rst_mosi", {31'd0, spi_mosi}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    access(4'h6, 8'h00);
    check("post_rst_status", {16'd0, rd_data}, 32'h0202);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
